chan_readout_packer: RTL

- Snapshots NCH channels of DW-bit analog-register data into a byte-addressed readout image for the SPI peripheral's read-only register space.
- Each channel occupies BPC = ceil(DW/8) consecutive bytes, least-significant byte first. Unused top bits of each channel's last byte read as 0.
- The image is reachable two ways: by addressed register read (SPI register map) and by a sequential valid/ready byte stream (burst readout).
- The snapshot stays frozen during readout, so a burst is coherent even while the analog side keeps updating.

---
 rtl/chan_readout_packer_if.sv | 24 ++
 rtl/chan_readout_packer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/chan_readout_packer_if.sv
// Byte-stream and register-read bus of the channel readout packer.
// The master side is the SPI peripheral / burst consumer, the slave side is the packer.
interface chan_readout_packer_if #(
    parameter int AW = 8
);
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_hit;

    modport master (
        input  out_byte, out_valid, out_last, rd_data, rd_hit,
        output out_ready, rd_addr, rd_en
    );

    modport slave (
        output out_byte, out_valid, out_last, rd_data, rd_hit,
        input  out_ready, rd_addr, rd_en
    );
endinterface

// File: rtl/chan_readout_packer.sv
// Freezes a snapshot of NCH analog-register channels and serves it as a byte image,
// both by addressed register read and as a valid/ready burst.
//
//   state  | meaning
//   IDLE   | no burst; capture refreshes the snapshot, stream_start opens a burst
//   STREAM | presenting image[idx]; snapshot frozen, capture only flags overrun
module chan_readout_packer #(
    parameter int NCH       = 8,
    parameter int DW        = 50,
    parameter int BASE_ADDR = 4,
    parameter int AW        = 8
) (
    input  logic                    iclk,
    input  logic                    rstn,
    input  logic [NCH*DW-1:0]       ch_data,
    input  logic                    capture,
    input  logic                    stream_start,
    input  logic                    clr_overrun,
    output logic                    snap_valid,
    output logic                    busy,
    output logic                    overrun,
    chan_readout_packer_if.slave    bus
);
    localparam int BPC    = (DW + 7) / 8;
    localparam int NBYTES = NCH * BPC;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [AW:0]   ADDR_LO  = (AW + 1)'(BASE_ADDR);
    localparam logic [AW:0]   ADDR_HI  = (AW + 1)'(BASE_ADDR + NBYTES);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       idx, idx_nx;
    logic                do_cap, ovr_set;
    logic [NCH*DW-1:0]   snap;
    logic [NBYTES*8-1:0] padded;
    logic [7:0]          image [NBYTES];
    logic [AW:0]         rd_ext, rd_off;
    logic                rd_in;
    logic [7:0]          rd_byte;

    // Each channel is zero-padded up to a whole number of bytes, LSB first.
    always_comb begin
        padded = '0;
        for (int c = 0; c < NCH; c++) begin
            padded[c*BPC*8 +: DW] = snap[c*DW +: DW];
        end
    end

    always_comb begin
        for (int k = 0; k < NBYTES; k++) begin
            image[k] = padded[k*8 +: 8];
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        do_cap   = 1'b0;
        ovr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    do_cap = 1'b1;
                end else if (stream_start && snap_valid) begin
                    state_nx = STREAM;
                    idx_nx   = '0;
                end
            end
            STREAM: begin
                ovr_set = capture;
                if (bus.out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    assign busy          = (state == STREAM);
    assign bus.out_valid = busy;
    assign bus.out_byte  = busy ? image[idx] : 8'h00;
    assign bus.out_last  = busy && (idx == LAST_IDX);

    // One extra address bit keeps BASE_ADDR+NBYTES from wrapping at the top of the map.
    assign rd_ext = {1'b0, bus.rd_addr};
    assign rd_in  = (rd_ext >= ADDR_LO) && (rd_ext < ADDR_HI);
    assign rd_off = rd_ext - ADDR_LO;

    always_comb begin
        rd_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (rd_off == (AW + 1)'(k)) begin
                rd_byte = image[k];
            end
        end
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            snap        <= '0;
            snap_valid  <= 1'b0;
            overrun     <= 1'b0;
            bus.rd_data <= 8'h00;
            bus.rd_hit  <= 1'b0;
        end else begin
            if (do_cap) begin
                snap       <= ch_data;
                snap_valid <= 1'b1;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
            if (bus.rd_en) begin
                bus.rd_data <= rd_in ? rd_byte : 8'h00;
                bus.rd_hit  <= rd_in;
            end
        end
    end
endmodule
